// File: rtl/ln_pkg.sv
// ln_pkg: shared widths, state encoding and saturation helper for the LN/RMS statistics accumulator.
package ln_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int DRAIN_LEN = 5;

    function automatic int f_tw(input int tout);
        return $clog2(tout);
    endfunction

    function automatic int f_cw(input int ch_max);
        return $clog2(ch_max);
    endfunction

    function automatic int f_sw(input int dw, input int ch_max);
        return dw + $clog2(ch_max);
    endfunction

    function automatic int f_qw(input int dw, input int ch_max);
        return 2 * dw + $clog2(ch_max);
    endfunction

    function automatic longint f_smax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/ln_stat_pipe.sv
// ln_stat_pipe: multiply by reciprocal, round/saturate, square the mean and form variance or mean square.
module ln_stat_pipe
    import ln_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 32,
    parameter int SW = 28,
    parameter int QW = 44,
    parameter int TW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_mode,
    input  logic [RW:0]       i_recip,
    input  logic              i_vld,
    input  logic              i_last,
    input  logic [TW-1:0]     i_idx,
    input  logic [SW-1:0]     i_sum,
    input  logic [QW-1:0]     i_sq,
    output logic              o_vld,
    output logic              o_done,
    output logic [TW-1:0]     o_idx,
    output logic [DW-1:0]     o_mean,
    output logic [2*DW-1:0]   o_var,
    output logic              o_sat
);

    localparam int MW = SW + RW + 2;
    localparam int NW = QW + RW + 1;
    localparam logic signed [MW-1:0] L_MHALF = MW'(1) <<< (RW - 1);
    localparam logic        [NW-1:0] L_QHALF = NW'(1) << (RW - 1);
    localparam logic signed [MW-1:0] L_MMAX  = MW'(f_smax(DW));
    localparam logic signed [MW-1:0] L_MMIN  = -L_MMAX - MW'(1);
    localparam logic        [NW-1:0] L_QMAX  = NW'(f_smax(2 * DW));
    localparam logic      [2*DW-1:0] L_VMAX  = {1'b0, {(2*DW-1){1'b1}}};

    logic                  r2_vld, r3_vld, r4_vld;
    logic                  r2_last, r3_last, r4_last;
    logic [TW-1:0]         r2_idx, r3_idx, r4_idx;
    logic signed [MW-1:0]  r2_m;
    logic [NW-1:0]         r2_q;
    logic signed [DW-1:0]  r3_mean, r4_mean;
    logic [2*DW-1:0]       r3_msq, r4_msq, r4_m2;
    logic                  r3_sat, r4_sat;

    logic signed [MW-1:0]  w_mr;
    logic [NW-1:0]         w_qr;
    logic                  w_mhi, w_mlo, w_qhi;
    logic [DW-1:0]         w_mean;
    logic [2*DW-1:0]       w_msq;
    logic signed [2*DW:0]  w_d;
    logic                  w_neg, w_ovf;
    logic [2*DW-1:0]       w_var;
    logic                  w_sat5;

    // Rounding is half-up: add half an LSB before the (arithmetic) shift.
    always_comb begin
        w_mr   = (r2_m + L_MHALF) >>> RW;
        w_qr   = (r2_q + L_QHALF) >> RW;
        w_mhi  = w_mr > L_MMAX;
        w_mlo  = w_mr < L_MMIN;
        w_qhi  = w_qr > L_QMAX;
        w_mean = w_mhi ? {1'b0, {(DW-1){1'b1}}} : w_mlo ? {1'b1, {(DW-1){1'b0}}} : w_mr[DW-1:0];
        w_msq  = w_qhi ? L_VMAX : w_qr[2*DW-1:0];
        w_d    = $signed({1'b0, r4_msq}) - $signed({1'b0, r4_m2});
        w_neg  = w_d[2*DW];
        w_ovf  = !w_neg && w_d[2*DW-1];
        w_var  = i_mode ? r4_msq : w_neg ? '0 : w_ovf ? L_VMAX : w_d[2*DW-1:0];
        w_sat5 = r4_sat || (!i_mode && (w_neg || w_ovf));
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r2_vld <= 1'b0;
            r3_vld <= 1'b0;
            r4_vld <= 1'b0;
            o_vld  <= 1'b0;
            o_done <= 1'b0;
        end else begin
            r2_vld <= i_vld;
            r3_vld <= r2_vld;
            r4_vld <= r3_vld;
            o_vld  <= r4_vld;
            o_done <= r4_vld && r4_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            o_sat <= 1'b0;
        end else begin
            o_sat <= o_sat || (r4_vld && w_sat5);
        end
    end

    always_ff @(posedge clk) begin
        r2_m    <= MW'($signed(i_sum)) * MW'($signed({1'b0, i_recip}));
        r2_q    <= NW'(i_sq) * NW'(i_recip);
        r2_idx  <= i_idx;
        r2_last <= i_last;
        r3_mean <= w_mean;
        r3_msq  <= w_msq;
        r3_sat  <= w_mhi || w_mlo || w_qhi;
        r3_idx  <= r2_idx;
        r3_last <= r2_last;
        r4_m2   <= r3_mean * r3_mean;
        r4_mean <= r3_mean;
        r4_msq  <= r3_msq;
        r4_sat  <= r3_sat;
        r4_idx  <= r3_idx;
        r4_last <= r3_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_idx  <= '0;
            o_mean <= '0;
            o_var  <= '0;
        end else if (r4_vld) begin
            o_idx  <= r4_idx;
            o_mean <= r4_mean;
            o_var  <= w_var;
        end
    end

endmodule

// File: rtl/ln_stat_acc.sv
// ln_stat_acc: per-position sum / sum-of-squares accumulation across channel groups,
// emitting rounded, saturated mean and variance (LN) or mean square (RMS).
module ln_stat_acc
    import ln_pkg::*;
#(
    parameter int DW = 16,
    parameter int LANES = 32,
    parameter int TOUT = 32,
    parameter int CH_MAX = 4096,
    parameter int RW = 2 * DW,
    localparam int LW = $clog2(LANES),
    localparam int TW = f_tw(TOUT),
    localparam int CW = f_cw(CH_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic              cfg_clr,
    input  logic              cfg_mode,
    input  logic [TW:0]       cfg_pos,
    input  logic [CW-LW:0]    cfg_grp,
    input  logic [RW:0]       cfg_recip,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DW+LW-1:0]  in_sum,
    input  logic [2*DW+LW-1:0] in_sqsum,
    output logic              out_vld,
    output logic [TW-1:0]     out_idx,
    output logic [DW-1:0]     out_mean,
    output logic [2*DW-1:0]   out_var,
    output logic              done,
    output logic              err,
    output logic              sat
);

    localparam int SW = f_sw(DW, CH_MAX);
    localparam int QW = f_qw(DW, CH_MAX);
    localparam int GW = CW - LW;

    state_t            r_state;
    logic              r_mode;
    logic [TW:0]       r_cfg_pos;
    logic [GW:0]       r_cfg_grp;
    logic [RW:0]       r_recip;
    logic [TW-1:0]     r_pos;
    logic [GW-1:0]     r_grp;
    logic [2:0]        r_dcnt;
    logic              r_err;
    logic [SW-1:0]     r_acc_sum [TOUT];
    logic [QW-1:0]     r_acc_sq  [TOUT];
    logic              r_s1_vld, r_s1_last;
    logic [TW-1:0]     r_s1_idx;
    logic [SW-1:0]     r_s1_sum;
    logic [QW-1:0]     r_s1_sq;

    logic              w_acc, w_pos_last, w_grp_last;
    logic [SW-1:0]     w_sum_x, w_sum_n;
    logic [QW-1:0]     w_sq_x, w_sq_n;

    assign in_rdy = r_state == RUN;
    assign err    = r_err;

    always_comb begin
        w_acc      = in_vld && in_rdy;
        w_pos_last = {1'b0, r_pos} == r_cfg_pos - 1'b1;
        w_grp_last = {1'b0, r_grp} == r_cfg_grp - 1'b1;
        w_sum_x    = {{(SW-DW-LW){in_sum[DW+LW-1]}}, in_sum};
        w_sq_x     = {{(QW-2*DW-LW){1'b0}}, in_sqsum};
        w_sum_n    = (r_grp == '0) ? w_sum_x : r_acc_sum[r_pos] + w_sum_x;
        w_sq_n     = (r_grp == '0) ? w_sq_x : r_acc_sq[r_pos] + w_sq_x;
    end

    always_ff @(posedge clk) begin
        if (rst || cfg_clr) begin
            r_state  <= IDLE;
            r_pos    <= '0;
            r_grp    <= '0;
            r_dcnt   <= '0;
            r_err    <= 1'b0;
            r_s1_vld <= 1'b0;
        end else begin
            r_err    <= r_err || (in_vld && !in_rdy);
            r_s1_vld <= w_acc && w_grp_last;
            case (r_state)
                IDLE: begin
                    r_pos   <= '0;
                    r_grp   <= '0;
                    r_state <= cfg_load ? RUN : IDLE;
                end
                RUN: begin
                    if (w_acc) begin
                        r_pos <= w_pos_last ? '0 : r_pos + 1'b1;
                        if (w_pos_last) r_grp <= w_grp_last ? '0 : r_grp + 1'b1;
                        if (w_pos_last && w_grp_last) begin
                            r_state <= DRAIN;
                            r_dcnt  <= '0;
                        end
                    end
                end
                default: begin
                    r_dcnt  <= r_dcnt + 1'b1;
                    r_state <= (r_dcnt == 3'(DRAIN_LEN - 1)) ? RUN : DRAIN;
                end
            endcase
        end
    end

    // Configuration is latched only from IDLE so a running stripe never sees it change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode    <= 1'b0;
            r_cfg_pos <= '0;
            r_cfg_grp <= '0;
            r_recip   <= '0;
        end else if (r_state == IDLE && cfg_load && !cfg_clr) begin
            r_mode    <= cfg_mode;
            r_cfg_pos <= cfg_pos;
            r_cfg_grp <= cfg_grp;
            r_recip   <= cfg_recip;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_acc_sum[r_pos] <= w_sum_n;
            r_acc_sq[r_pos]  <= w_sq_n;
        end
        r_s1_sum  <= w_sum_n;
        r_s1_sq   <= w_sq_n;
        r_s1_idx  <= r_pos;
        r_s1_last <= w_pos_last;
    end

    ln_stat_pipe #(
        .DW (DW),
        .RW (RW),
        .SW (SW),
        .QW (QW),
        .TW (TW)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_flush (cfg_clr),
        .i_mode  (r_mode),
        .i_recip (r_recip),
        .i_vld   (r_s1_vld),
        .i_last  (r_s1_last),
        .i_idx   (r_s1_idx),
        .i_sum   (r_s1_sum),
        .i_sq    (r_s1_sq),
        .o_vld   (out_vld),
        .o_done  (done),
        .o_idx   (out_idx),
        .o_mean  (out_mean),
        .o_var   (out_var),
        .o_sat   (sat)
    );

endmodule

// File: tb/tb_ln_stat_acc.sv
// tb_ln_stat_acc: directed scenarios with a queue scoreboard checked by an independent output monitor.
module tb_ln_stat_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 1'b0;
    logic        cfg_clr = 1'b0;
    logic        cfg_mode = 1'b0;
    logic [5:0]  cfg_pos = '0;
    logic [7:0]  cfg_grp = '0;
    logic [32:0] cfg_recip = '0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [20:0] in_sum = '0;
    logic [36:0] in_sqsum = '0;
    logic        out_vld;
    logic [4:0]  out_idx;
    logic [15:0] out_mean;
    logic [31:0] out_var;
    logic        done;
    logic        err;
    logic        sat;

    typedef struct {
        int     idx;
        int     mean;
        longint vr;
        bit     dn;
        int     cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   nv = 0;
    int   nd = 0;

    ln_stat_acc dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_clr   (cfg_clr),
        .cfg_mode  (cfg_mode),
        .cfg_pos   (cfg_pos),
        .cfg_grp   (cfg_grp),
        .cfg_recip (cfg_recip),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_sum    (in_sum),
        .in_sqsum  (in_sqsum),
        .out_vld   (out_vld),
        .out_idx   (out_idx),
        .out_mean  (out_mean),
        .out_var   (out_var),
        .done      (done),
        .err       (err),
        .sat       (sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (done) nd++;
            if (out_vld) begin
                nv++;
                if (q.size() == 0) begin
                    chk("unexpected_vld", longint'(out_vld), 0);
                end else begin
                    e = q.pop_front();
                    chk("idx", longint'(out_idx), e.idx);
                    chk("mean", longint'($signed(out_mean)), e.mean);
                    chk("var", longint'(out_var), e.vr);
                    chk("done", longint'(done), e.dn);
                    chk("latency", cyc, e.cyc);
                end
            end else if (done) begin
                chk("done_wo_vld", longint'(done), 0);
            end
        end
    end

    task automatic cfg(input bit m, input int p, input int g, input longint r);
        cfg_mode  = m;
        cfg_pos   = 6'(p);
        cfg_grp   = 8'(g);
        cfg_recip = 33'(r);
        cfg_load  = 1'b1;
        @(negedge clk);
        cfg_load  = 1'b0;
    endtask

    task automatic clr();
        cfg_clr = 1'b1;
        @(negedge clk);
        cfg_clr = 1'b0;
    endtask

    task automatic send(input int s, input longint sq, input bit push,
                        input int idx, input int mn, input longint vr, input bit dn);
        in_vld   = 1'b1;
        in_sum   = 21'(s);
        in_sqsum = 37'(sq);
        if (push && in_rdy) q.push_back('{idx, mn, vr, dn, cyc + 5});
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic settle();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        chk("pending_results", q.size(), 0);
        q.delete();
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 20 && !in_rdy; i++) @(negedge clk);
        chk("in_rdy_run", longint'(in_rdy), 1);
    endtask

    task automatic stripe2(input bit push, input longint vr);
        send(64, 256, 0, 0, 0, 0, 0);
        send(-64, 256, 0, 0, 0, 0, 0);
        send(64, 256, push, 0, 2, vr, 0);
        send(-64, 256, push, 1, -2, vr, 1);
    endtask

    initial begin
        int nv0, nd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_rdy", longint'(in_rdy), 0);
        chk("rst_out_vld", longint'(out_vld), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_err", longint'(err), 0);
        chk("rst_sat", longint'(sat), 0);
        chk("rst_mean", longint'(out_mean), 0);
        chk("rst_var", longint'(out_var), 0);
        chk("rst_idx", longint'(out_idx), 0);

        // 1: single position, single group
        cfg(0, 1, 1, 64'd1 << 27);
        chk("cfg_in_rdy", longint'(in_rdy), 1);
        send(320, 3200, 1, 0, 10, 0, 1);
        settle();
        chk("t1_sat", longint'(sat), 0);
        clr();

        // 2: two positions, two groups, LN; second stripe reuses held config
        cfg(0, 2, 2, 64'd1 << 26);
        stripe2(1, 4);
        settle();
        wait_rdy();
        stripe2(1, 4);
        settle();
        chk("t2_sat", longint'(sat), 0);
        clr();

        // 3: RMS mode
        cfg(1, 2, 2, 64'd1 << 26);
        stripe2(1, 8);
        settle();
        clr();

        // 4: mean saturation, LN variance clamps to zero
        cfg(0, 1, 1, 64'd1 << 27);
        send((1 << 20) - 1, 0, 1, 0, 32767, 0, 1);
        settle();
        chk("t4_sat", longint'(sat), 1);
        wait_rdy();

        // 5: beat during DRAIN is dropped
        send(320, 3200, 1, 0, 10, 0, 1);
        chk("t5_rdy_drain", longint'(in_rdy), 0);
        send(320, 3200, 1, 0, 10, 0, 1);
        chk("t5_err", longint'(err), 1);
        settle();
        clr();
        chk("t5_err_clr", longint'(err), 0);
        chk("t5_sat_clr", longint'(sat), 0);
        chk("t5_idle", longint'(in_rdy), 0);

        // 6: abort after 3 of 4 beats, then rerun
        cfg(0, 2, 2, 64'd1 << 26);
        nv0 = nv;
        nd0 = nd;
        send(64, 256, 0, 0, 0, 0, 0);
        send(-64, 256, 0, 0, 0, 0, 0);
        send(64, 256, 0, 0, 0, 0, 0);
        clr();
        repeat (12) @(negedge clk);
        chk("t6_no_vld", nv - nv0, 0);
        chk("t6_no_done", nd - nd0, 0);
        chk("t6_idle", longint'(in_rdy), 0);
        cfg(0, 2, 2, 64'd1 << 26);
        stripe2(1, 4);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
